// File: rtl/axi_burst_write_ctrl.sv
// AXI4 write slave bridging to a single-port req/grant memory, with a queued AW channel.
// FIXED/INCR/WRAP bursts are supported; malformed bursts are drained and answered with SLVERR.
module axi_burst_write_ctrl #(
    parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
    parameter int unsigned AXI4_WDATA_WIDTH   = 64,
    parameter int unsigned AXI4_ID_WIDTH      = 16,
    parameter int unsigned AXI4_USER_WIDTH    = 10,
    parameter int unsigned AXI_NUMBYTES       = AXI4_WDATA_WIDTH / 8,
    parameter int unsigned MEM_ADDR_WIDTH     = 13,
    parameter int unsigned AW_FIFO_DEPTH      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AXI4_ID_WIDTH-1:0]      AWID_i,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] AWADDR_i,
    input  logic [7:0]                    AWLEN_i,
    input  logic [2:0]                    AWSIZE_i,
    input  logic [1:0]                    AWBURST_i,
    input  logic [AXI4_USER_WIDTH-1:0]    AWUSER_i,
    input  logic                          AWVALID_i,
    output logic                          AWREADY_o,
    input  logic [AXI4_WDATA_WIDTH-1:0]   WDATA_i,
    input  logic [AXI_NUMBYTES-1:0]       WSTRB_i,
    input  logic                          WLAST_i,
    input  logic                          WVALID_i,
    output logic                          WREADY_o,
    output logic [AXI4_ID_WIDTH-1:0]      BID_o,
    output logic [AXI4_USER_WIDTH-1:0]    BUSER_o,
    output logic [1:0]                    BRESP_o,
    output logic                          BVALID_o,
    input  logic                          BREADY_i,
    output logic                          MEM_CEN_o,
    output logic                          MEM_WEN_o,
    output logic [MEM_ADDR_WIDTH-1:0]     MEM_A_o,
    output logic [AXI4_WDATA_WIDTH-1:0]   MEM_D_o,
    output logic [AXI_NUMBYTES-1:0]       MEM_BE_o,
    output logic                          valid_o,
    input  logic                          grant_i
);

    localparam int unsigned PTR_W    = $clog2(AW_FIFO_DEPTH);
    localparam int unsigned SIZE_MAX = $clog2(AXI_NUMBYTES);
    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ONE = MEM_ADDR_WIDTH'(1);
    localparam logic [PTR_W:0]            FULL_CNT = (PTR_W + 1)'(AW_FIFO_DEPTH);

    typedef struct packed {
        logic [AXI4_ID_WIDTH-1:0]   id;
        logic [AXI4_USER_WIDTH-1:0] user;
        logic [MEM_ADDR_WIDTH-1:0]  addr;
        logic [7:0]                 len;
        logic [2:0]                 size;
        logic [1:0]                 burst;
        logic                       err;
    } aw_entry_t;

    typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_RESP} state_e;

    state_e              state_q, state_d;
    aw_entry_t           fifo_q [AW_FIFO_DEPTH];
    aw_entry_t           fifo_d [AW_FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    aw_entry_t           work_q, work_d;
    logic [8:0]          beat_q, beat_d;

    logic                fifo_empty, aw_push, pop, w_ready, w_acc;
    aw_entry_t           aw_entry;
    logic [MEM_ADDR_WIDTH-1:0] step, mask, next_addr;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^AWADDR_i;
    assign fifo_empty = (count_q == '0);
    assign AWREADY_o  = (count_q != FULL_CNT) && !rst;
    assign aw_push    = AWVALID_i && AWREADY_o;

    always_comb begin
        aw_entry       = '0;
        aw_entry.id    = AWID_i;
        aw_entry.user  = AWUSER_i;
        aw_entry.addr  = AWADDR_i[MEM_ADDR_WIDTH-1:0];
        aw_entry.len   = AWLEN_i;
        aw_entry.size  = AWSIZE_i;
        aw_entry.burst = AWBURST_i;
        aw_entry.err   = (32'(AWSIZE_i) > SIZE_MAX) || (AWBURST_i == 2'b11) ||
                         ((AWBURST_i == 2'b10) && !(AWLEN_i inside {8'd1, 8'd3, 8'd7, 8'd15}));
    end

    // WRAP keeps the upper bits and wraps the low bits within the (len+1)*step window
    always_comb begin
        step = ADDR_ONE << work_q.size;
        mask = ((MEM_ADDR_WIDTH'(work_q.len) + ADDR_ONE) << work_q.size) - ADDR_ONE;
        case (work_q.burst)
            2'b00:   next_addr = work_q.addr;
            2'b10:   next_addr = (work_q.addr & ~mask) | ((work_q.addr + step) & mask);
            default: next_addr = work_q.addr + step;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        beat_d    = beat_q;
        pop       = 1'b0;
        w_ready   = 1'b0;
        valid_o   = 1'b0;
        MEM_CEN_o = 1'b1;
        BVALID_o  = 1'b0;
        BRESP_o   = 2'b00;
        w_acc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (work_q.err) begin
                    w_ready = 1'b1;
                end else begin
                    valid_o   = WVALID_i;
                    w_ready   = grant_i;
                    MEM_CEN_o = ~(WVALID_i & grant_i);
                end
                w_acc = WVALID_i && w_ready;
                if (w_acc) begin
                    if (beat_q == {1'b0, work_q.len}) begin
                        if (!WLAST_i) work_d.err = 1'b1;
                        state_d = ST_RESP;
                    end else if (WLAST_i) begin
                        work_d.err = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        beat_d      = beat_q + 9'd1;
                        work_d.addr = next_addr;
                    end
                end
            end
            ST_RESP: begin
                BVALID_o = 1'b1;
                BRESP_o  = work_q.err ? 2'b10 : 2'b00;
                if (BREADY_i) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_BURST;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pop) begin
            work_d = fifo_q[rd_ptr_q];
            beat_d = '0;
        end
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (aw_push) begin
            fifo_d[wr_ptr_q] = aw_entry;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({aw_push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            work_q   <= '0;
            beat_q   <= '0;
            for (int unsigned i = 0; i < AW_FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            work_q   <= work_d;
            beat_q   <= beat_d;
            fifo_q   <= fifo_d;
        end
    end

    assign WREADY_o  = w_ready;
    assign BID_o     = work_q.id;
    assign BUSER_o   = work_q.user;
    assign MEM_WEN_o = 1'b0;
    assign MEM_A_o   = work_q.addr;
    assign MEM_D_o   = WDATA_i;
    assign MEM_BE_o  = WSTRB_i;

endmodule

// File: tb/tb_axi_burst_write_ctrl.sv
// Directed self-checking bench for axi_burst_write_ctrl (64-bit data, 13-bit memory address).
module tb_axi_burst_write_ctrl;

    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] AWID_i;
    logic [31:0] AWADDR_i;
    logic [7:0]  AWLEN_i;
    logic [2:0]  AWSIZE_i;
    logic [1:0]  AWBURST_i;
    logic [9:0]  AWUSER_i;
    logic        AWVALID_i, AWREADY_o;
    logic [63:0] WDATA_i;
    logic [7:0]  WSTRB_i;
    logic        WLAST_i, WVALID_i, WREADY_o;
    logic [15:0] BID_o;
    logic [9:0]  BUSER_o;
    logic [1:0]  BRESP_o;
    logic        BVALID_o, BREADY_i;
    logic        MEM_CEN_o, MEM_WEN_o;
    logic [12:0] MEM_A_o;
    logic [63:0] MEM_D_o;
    logic [7:0]  MEM_BE_o;
    logic        valid_o, grant_i;

    int errors = 0;
    int checks = 0;

    logic [12:0] wr_a [$];
    logic [63:0] wr_d [$];
    logic [7:0]  wr_be [$];
    logic [15:0] b_id [$];
    logic [1:0]  b_resp [$];
    logic [9:0]  b_user [$];

    axi_burst_write_ctrl #(
        .AXI4_ADDRESS_WIDTH(32), .AXI4_WDATA_WIDTH(64), .AXI4_ID_WIDTH(16),
        .AXI4_USER_WIDTH(10), .AXI_NUMBYTES(8), .MEM_ADDR_WIDTH(13), .AW_FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .AWID_i(AWID_i), .AWADDR_i(AWADDR_i), .AWLEN_i(AWLEN_i), .AWSIZE_i(AWSIZE_i),
        .AWBURST_i(AWBURST_i), .AWUSER_i(AWUSER_i), .AWVALID_i(AWVALID_i), .AWREADY_o(AWREADY_o),
        .WDATA_i(WDATA_i), .WSTRB_i(WSTRB_i), .WLAST_i(WLAST_i), .WVALID_i(WVALID_i), .WREADY_o(WREADY_o),
        .BID_o(BID_o), .BUSER_o(BUSER_o), .BRESP_o(BRESP_o), .BVALID_o(BVALID_o), .BREADY_i(BREADY_i),
        .MEM_CEN_o(MEM_CEN_o), .MEM_WEN_o(MEM_WEN_o), .MEM_A_o(MEM_A_o), .MEM_D_o(MEM_D_o),
        .MEM_BE_o(MEM_BE_o), .valid_o(valid_o), .grant_i(grant_i)
    );

    always #5 clk = ~clk;

    // Record every memory write and every B handshake as seen at the clock edge
    always @(posedge clk) begin
        if (!rst && !MEM_CEN_o) begin
            wr_a.push_back(MEM_A_o);
            wr_d.push_back(MEM_D_o);
            wr_be.push_back(MEM_BE_o);
        end
        if (!rst && BVALID_o && BREADY_i) begin
            b_id.push_back(BID_o);
            b_resp.push_back(BRESP_o);
            b_user.push_back(BUSER_o);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [15:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [9:0] user,
                           output bit tmo);
        int cyc = 0;
        AWID_i = id; AWADDR_i = addr; AWLEN_i = len; AWSIZE_i = size;
        AWBURST_i = burst; AWUSER_i = user; AWVALID_i = 1'b1;
        tmo = 1'b0;
        while (AWREADY_o !== 1'b1 && cyc < 40) begin
            cycle();
            cyc++;
        end
        if (cyc >= 40) tmo = 1'b1;
        cycle();
        AWVALID_i = 1'b0;
    endtask

    task automatic send_w(input int n, input int last_beat, input bit tog, output int mism, output bit tmo);
        mism = 0;
        tmo  = 1'b0;
        for (int i = 0; i < n; i++) begin
            int cyc = 0;
            WVALID_i = 1'b1;
            WDATA_i  = 64'hDA7A_0000_0000_0000 | 64'(i);
            WSTRB_i  = 8'hF0 ^ 8'(i);
            WLAST_i  = (i == last_beat);
            #1;
            if (tog && WREADY_o !== grant_i) mism++;
            while (WREADY_o !== 1'b1 && cyc < 40) begin
                cycle();
                if (tog) grant_i = ~grant_i;
                #1;
                if (tog && WREADY_o !== grant_i) mism++;
                cyc++;
            end
            if (cyc >= 40) tmo = 1'b1;
            cycle();
            if (tog) grant_i = ~grant_i;
        end
        WVALID_i = 1'b0;
        WLAST_i  = 1'b0;
    endtask

    task automatic wait_b(output bit tmo);
        int cyc = 0;
        BREADY_i = 1'b1;
        #1;
        while (BVALID_o !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        tmo = (cyc >= 100);
        cycle();
        BREADY_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; AWVALID_i = 0; AWID_i = 0; AWADDR_i = 0; AWLEN_i = 0; AWSIZE_i = 0;
        AWBURST_i = 0; AWUSER_i = 0; WDATA_i = 0; WSTRB_i = 0; WLAST_i = 0; WVALID_i = 0;
        BREADY_i = 0; grant_i = 0;
        repeat (3) cycle();
        checks++; if (AWREADY_o !== 1'b0) begin errors++; $display("FAIL rst_awready got=%b exp=0", AWREADY_o); end
        checks++; if (WREADY_o !== 1'b0) begin errors++; $display("FAIL rst_wready got=%b exp=0", WREADY_o); end
        checks++; if (BVALID_o !== 1'b0) begin errors++; $display("FAIL rst_bvalid got=%b exp=0", BVALID_o); end
        checks++; if (BRESP_o !== 2'b00) begin errors++; $display("FAIL rst_bresp got=%b exp=00", BRESP_o); end
        checks++; if (BID_o !== 16'h0) begin errors++; $display("FAIL rst_bid got=%h exp=0", BID_o); end
        checks++; if (BUSER_o !== 10'h0) begin errors++; $display("FAIL rst_buser got=%h exp=0", BUSER_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", valid_o); end
        checks++; if (MEM_CEN_o !== 1'b1) begin errors++; $display("FAIL rst_cen got=%b exp=1", MEM_CEN_o); end
        rst = 1'b0;
        cycle();
        checks++; if (AWREADY_o !== 1'b1) begin errors++; $display("FAIL post_rst_awready got=%b exp=1", AWREADY_o); end
    endtask

    task automatic test_single_beat();
        int wb, bb, mism; bit t1, t2, t3;
        wb = wr_a.size(); bb = b_id.size();
        grant_i = 1'b1;
        send_aw(16'h1234, 32'h0000_0100, 8'd0, 3'd3, INCR, 10'h2A, t1);
        checks++; if (WREADY_o !== 1'b0) begin errors++; $display("FAIL single_aw_latency wready got=%b exp=0", WREADY_o); end
        send_w(1, 0, 1'b0, mism, t2);
        wait_b(t3);
        checks++; if ({t1, t2, t3} !== 3'b000) begin errors++; $display("FAIL single_timeout got=%b exp=000", {t1, t2, t3}); end
        checks++; if (wr_a.size() - wb !== 1) begin errors++; $display("FAIL single_nwrites got=%0d exp=1", wr_a.size() - wb); end
        if (wr_a.size() > wb) begin
            checks++; if (wr_a[wb] !== 13'h100) begin errors++; $display("FAIL single_addr got=%h exp=100", wr_a[wb]); end
            checks++; if (wr_d[wb] !== 64'hDA7A_0000_0000_0000) begin errors++; $display("FAIL single_data got=%h exp=da7a000000000000", wr_d[wb]); end
            checks++; if (wr_be[wb] !== 8'hF0) begin errors++; $display("FAIL single_be got=%h exp=f0", wr_be[wb]); end
        end
        checks++; if (b_id.size() - bb !== 1) begin errors++; $display("FAIL single_nresp got=%0d exp=1", b_id.size() - bb); end
        if (b_id.size() > bb) begin
            checks++; if (b_id[bb] !== 16'h1234) begin errors++; $display("FAIL single_bid got=%h exp=1234", b_id[bb]); end
            checks++; if (b_resp[bb] !== 2'b00) begin errors++; $display("FAIL single_bresp got=%b exp=00", b_resp[bb]); end
            checks++; if (b_user[bb] !== 10'h2A) begin errors++; $display("FAIL single_buser got=%h exp=02a", b_user[bb]); end
        end
        checks++; if (MEM_WEN_o !== 1'b0) begin errors++; $display("FAIL single_wen got=%b exp=0", MEM_WEN_o); end
    endtask

    task automatic test_incr_grant_toggle();
        logic [12:0] exp_a [4] = '{13'h20, 13'h24, 13'h28, 13'h2C};
        int wb, bb, mism; bit t1, t2, t3;
        wb = wr_a.size(); bb = b_id.size();
        grant_i = 1'b1;
        send_aw(16'h0002, 32'h20, 8'd3, 3'd2, INCR, 10'h001, t1);
        cycle();
        send_w(4, 3, 1'b1, mism, t2);
        grant_i = 1'b1;
        wait_b(t3);
        repeat (5) cycle();
        checks++; if ({t1, t2, t3} !== 3'b000) begin errors++; $display("FAIL incr_timeout got=%b exp=000", {t1, t2, t3}); end
        checks++; if (mism !== 0) begin errors++; $display("FAIL incr_wready_tracks_grant mismatches=%0d exp=0", mism); end
        checks++; if (wr_a.size() - wb !== 4) begin errors++; $display("FAIL incr_nwrites got=%0d exp=4", wr_a.size() - wb); end
        for (int k = 0; k < 4; k++) begin
            if (wr_a.size() > wb + k) begin
                checks++; if (wr_a[wb+k] !== exp_a[k]) begin errors++; $display("FAIL incr_addr[%0d] got=%h exp=%h", k, wr_a[wb+k], exp_a[k]); end
            end
        end
        checks++; if (b_id.size() - bb !== 1) begin errors++; $display("FAIL incr_nresp got=%0d exp=1", b_id.size() - bb); end
        if (b_id.size() > bb) begin
            checks++; if ({b_id[bb], b_resp[bb]} !== {16'h0002, 2'b00}) begin errors++; $display("FAIL incr_b got=%h/%b exp=0002/00", b_id[bb], b_resp[bb]); end
        end
    endtask

    task automatic test_wrap();
        logic [12:0] exp_a [4] = '{13'h38, 13'h20, 13'h28, 13'h30};
        int wb, bb, mism; bit t1, t2, t3;
        wb = wr_a.size(); bb = b_id.size();
        grant_i = 1'b1;
        send_aw(16'h0003, 32'h38, 8'd3, 3'd3, WRAP, 10'h003, t1);
        cycle();
        send_w(4, 3, 1'b0, mism, t2);
        wait_b(t3);
        checks++; if ({t1, t2, t3} !== 3'b000) begin errors++; $display("FAIL wrap_timeout got=%b exp=000", {t1, t2, t3}); end
        checks++; if (wr_a.size() - wb !== 4) begin errors++; $display("FAIL wrap_nwrites got=%0d exp=4", wr_a.size() - wb); end
        for (int k = 0; k < 4; k++) begin
            if (wr_a.size() > wb + k) begin
                checks++; if (wr_a[wb+k] !== exp_a[k]) begin errors++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", k, wr_a[wb+k], exp_a[k]); end
            end
        end
        if (b_id.size() > bb) begin
            checks++; if ({b_id[bb], b_resp[bb]} !== {16'h0003, 2'b00}) begin errors++; $display("FAIL wrap_b got=%h/%b exp=0003/00", b_id[bb], b_resp[bb]); end
        end else begin
            checks++; errors++; $display("FAIL wrap_nresp got=0 exp=1");
        end
    endtask

    task automatic test_errors();
        int wb, bb, mism; bit t1, t2, t3, t4, t5, t6, t7, t8, t9;
        // Oversized AWSIZE: drained even with grant low, nothing written
        wb = wr_a.size(); bb = b_id.size();
        grant_i = 1'b0;
        send_aw(16'h0004, 32'h0, 8'd1, 3'd4, INCR, 10'h004, t1);
        cycle();
        checks++; if ({WREADY_o, valid_o, MEM_CEN_o} !== 3'b101) begin errors++; $display("FAIL err_size_drain wready/valid/cen got=%b exp=101", {WREADY_o, valid_o, MEM_CEN_o}); end
        send_w(2, 1, 1'b0, mism, t2);
        wait_b(t3);
        checks++; if (wr_a.size() - wb !== 0) begin errors++; $display("FAIL err_size_nwrites got=%0d exp=0", wr_a.size() - wb); end
        if (b_id.size() > bb) begin
            checks++; if ({b_id[bb], b_resp[bb]} !== {16'h0004, 2'b10}) begin errors++; $display("FAIL err_size_b got=%h/%b exp=0004/10", b_id[bb], b_resp[bb]); end
        end else begin
            checks++; errors++; $display("FAIL err_size_nresp got=0 exp=1");
        end
        // Early WLAST on beat 1 of a 4-beat INCR: both accepted beats reach memory, then SLVERR
        wb = wr_a.size(); bb = b_id.size();
        grant_i = 1'b1;
        send_aw(16'h0005, 32'h80, 8'd3, 3'd2, INCR, 10'h005, t4);
        cycle();
        send_w(2, 1, 1'b0, mism, t5);
        wait_b(t6);
        checks++; if (wr_a.size() - wb !== 2) begin errors++; $display("FAIL err_early_nwrites got=%0d exp=2", wr_a.size() - wb); end
        if (wr_a.size() > wb + 1) begin
            checks++; if ({wr_a[wb], wr_a[wb+1]} !== {13'h80, 13'h84}) begin errors++; $display("FAIL err_early_addr got=%h,%h exp=080,084", wr_a[wb], wr_a[wb+1]); end
        end
        if (b_id.size() > bb) begin
            checks++; if ({b_id[bb], b_resp[bb]} !== {16'h0005, 2'b10}) begin errors++; $display("FAIL err_early_b got=%h/%b exp=0005/10", b_id[bb], b_resp[bb]); end
        end else begin
            checks++; errors++; $display("FAIL err_early_nresp got=0 exp=1");
        end
        // WRAP with AWLEN=2 is illegal
        wb = wr_a.size(); bb = b_id.size();
        send_aw(16'h0006, 32'h0, 8'd2, 3'd2, WRAP, 10'h006, t7);
        cycle();
        send_w(3, 2, 1'b0, mism, t8);
        wait_b(t9);
        checks++; if (wr_a.size() - wb !== 0) begin errors++; $display("FAIL err_wraplen_nwrites got=%0d exp=0", wr_a.size() - wb); end
        if (b_id.size() > bb) begin
            checks++; if ({b_id[bb], b_resp[bb]} !== {16'h0006, 2'b10}) begin errors++; $display("FAIL err_wraplen_b got=%h/%b exp=0006/10", b_id[bb], b_resp[bb]); end
        end else begin
            checks++; errors++; $display("FAIL err_wraplen_nresp got=0 exp=1");
        end
        checks++; if ({t1, t2, t3, t4, t5, t6, t7, t8, t9} !== 9'b0) begin errors++; $display("FAIL err_timeout got=%b exp=0", {t1, t2, t3, t4, t5, t6, t7, t8, t9}); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_id [3] = '{16'h000A, 16'h000B, 16'h000C};
        logic [12:0] exp_a [3]  = '{13'h200, 13'h300, 13'h400};
        int wb, bb, mism; bit t1, t2, t3, t4, t5, t6, t7, t8, t9;
        wb = wr_a.size(); bb = b_id.size();
        grant_i = 1'b1; BREADY_i = 1'b0;
        send_aw(exp_id[0], 32'h200, 8'd0, 3'd3, INCR, 10'h00A, t1);
        send_aw(exp_id[1], 32'h300, 8'd0, 3'd3, INCR, 10'h00B, t2);
        send_aw(exp_id[2], 32'h400, 8'd0, 3'd3, INCR, 10'h00C, t3);
        checks++; if (AWREADY_o !== 1'b0) begin errors++; $display("FAIL b2b_full_awready got=%b exp=0", AWREADY_o); end
        send_w(1, 0, 1'b0, mism, t4);
        repeat (2) cycle();
        checks++; if ({BVALID_o, BID_o, AWREADY_o} !== {1'b1, exp_id[0], 1'b0}) begin errors++; $display("FAIL b2b_hold bvalid/bid/awready got=%b/%h/%b exp=1/000a/0", BVALID_o, BID_o, AWREADY_o); end
        wait_b(t5);
        checks++; if ({WREADY_o, BVALID_o, AWREADY_o} !== 3'b101) begin errors++; $display("FAIL b2b_no_idle wready/bvalid/awready got=%b exp=101", {WREADY_o, BVALID_o, AWREADY_o}); end
        send_w(1, 0, 1'b0, mism, t6);
        wait_b(t7);
        send_w(1, 0, 1'b0, mism, t8);
        wait_b(t9);
        checks++; if ({t1, t2, t3, t4, t5, t6, t7, t8, t9} !== 9'b0) begin errors++; $display("FAIL b2b_timeout got=%b exp=0", {t1, t2, t3, t4, t5, t6, t7, t8, t9}); end
        checks++; if (b_id.size() - bb !== 3) begin errors++; $display("FAIL b2b_nresp got=%0d exp=3", b_id.size() - bb); end
        for (int k = 0; k < 3; k++) begin
            if (b_id.size() > bb + k) begin
                checks++; if ({b_id[bb+k], b_resp[bb+k]} !== {exp_id[k], 2'b00}) begin errors++; $display("FAIL b2b_b[%0d] got=%h/%b exp=%h/00", k, b_id[bb+k], b_resp[bb+k], exp_id[k]); end
            end
            if (wr_a.size() > wb + k) begin
                checks++; if (wr_a[wb+k] !== exp_a[k]) begin errors++; $display("FAIL b2b_addr[%0d] got=%h exp=%h", k, wr_a[wb+k], exp_a[k]); end
            end
        end
    endtask

    task automatic test_fixed_and_reset();
        int wb, bb, mism; bit t1, t2, t3, t4, t5, t6;
        wb = wr_a.size(); bb = b_id.size();
        grant_i = 1'b1;
        send_aw(16'h0007, 32'h40, 8'd2, 3'd3, FIXED, 10'h007, t1);
        cycle();
        send_w(3, 2, 1'b0, mism, t2);
        wait_b(t3);
        checks++; if (wr_a.size() - wb !== 3) begin errors++; $display("FAIL fixed_nwrites got=%0d exp=3", wr_a.size() - wb); end
        for (int k = 0; k < 3; k++) begin
            if (wr_a.size() > wb + k) begin
                checks++; if (wr_a[wb+k] !== 13'h40) begin errors++; $display("FAIL fixed_addr[%0d] got=%h exp=040", k, wr_a[wb+k]); end
            end
        end
        if (b_id.size() > bb) begin
            checks++; if ({b_id[bb], b_resp[bb]} !== {16'h0007, 2'b00}) begin errors++; $display("FAIL fixed_b got=%h/%b exp=0007/00", b_id[bb], b_resp[bb]); end
        end else begin
            checks++; errors++; $display("FAIL fixed_nresp got=0 exp=1");
        end
        // Reset in the middle of a 4-beat burst with another AW queued behind it
        wb = wr_a.size();
        send_aw(16'h0008, 32'h60, 8'd3, 3'd3, FIXED, 10'h008, t4);
        send_aw(16'h0009, 32'h70, 8'd0, 3'd3, INCR, 10'h009, t5);
        send_w(2, -1, 1'b0, mism, t6);
        checks++; if (wr_a.size() - wb !== 2) begin errors++; $display("FAIL rstmid_prewrites got=%0d exp=2", wr_a.size() - wb); end
        rst = 1'b1;
        cycle();
        checks++; if ({AWREADY_o, WREADY_o, BVALID_o, valid_o, MEM_CEN_o} !== 5'b00001) begin errors++; $display("FAIL rstmid_outputs aw/w/b/valid/cen got=%b exp=00001", {AWREADY_o, WREADY_o, BVALID_o, valid_o, MEM_CEN_o}); end
        checks++; if ({BID_o, BRESP_o} !== 18'h0) begin errors++; $display("FAIL rstmid_bid_bresp got=%h/%b exp=0000/00", BID_o, BRESP_o); end
        rst = 1'b0;
        bb = b_id.size();
        BREADY_i = 1'b1;
        repeat (10) cycle();
        BREADY_i = 1'b0;
        checks++; if (b_id.size() - bb !== 0) begin errors++; $display("FAIL rstmid_no_bresp got=%0d exp=0", b_id.size() - bb); end
        checks++; if ({AWREADY_o, WREADY_o, BVALID_o} !== 3'b100) begin errors++; $display("FAIL rstmid_idle aw/w/b got=%b exp=100", {AWREADY_o, WREADY_o, BVALID_o}); end
        checks++; if ({t1, t2, t3, t4, t5, t6} !== 6'b0) begin errors++; $display("FAIL fixed_timeout got=%b exp=0", {t1, t2, t3, t4, t5, t6}); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_incr_grant_toggle();
        test_wrap();
        test_errors();
        test_back_to_back();
        test_fixed_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
